memory_loader: RTL
==================

# memory_loader

Debug-unit receive path: deserializes bytes from the UART receiver into memory-slot-wide words and writes them to consecutive addresses of the instruction memory. It sits between the UART RX block and the instruction memory's write port, under control of the debugger's top FSM. It is the inverse of the memory print path. Loading ends on a halt word or when the address space is full.

## Interface
- UART_BUS_SIZE, 8, width of one received byte
- MEMORY_SLOT_SIZE, 32, width of one memory word; must be an integer multiple of UART_BUS_SIZE
- MEMORY_ADDR_BUS_SIZE, 10, word-address width; capacity = 2^MEMORY_ADDR_BUS_SIZE words
- HALT_WORD, 32'hFFFF_FFFF, word value that terminates loading; it is itself written

Ports:
- i_clk  input  1  clock, all state changes on rising edge
- i_reset  input  1  reset, asynchronous, active-low
- i_start  input  1  begin a load, sampled only in IDLE
- i_rx_done  input  1  one-cycle pulse, i_rx_data valid in the same cycle
- i_rx_data  input  UART_BUS_SIZE  received byte
- o_wr_enable  output  1  memory write strobe, one cycle per word
- o_wr_addr  output  MEMORY_ADDR_BUS_SIZE  word address for the write
- o_wr_data  output  MEMORY_SLOT_SIZE  assembled word
- o_busy  output  1  high while not in IDLE
- o_end  output  1  level; set when loading finishes, cleared by the next accepted i_start
- o_overflow  output  1  level; set when memory fills with no halt word, cleared by the next accepted i_start

## Operation
- BYTES = MEMORY_SLOT_SIZE / UART_BUS_SIZE. Byte order is little-endian: the first byte of a word goes to bits [UART_BUS_SIZE-1:0].
- Internal registers: state, byte pointer ($clog2(BYTES)+1 bits), word buffer, address counter. All outputs are registered.
- IDLE:
  - i_start -> RECEIVE. Clears byte pointer, address, o_end and o_overflow. Sets o_busy.
  - i_rx_done is ignored, including when it coincides with i_start.
- RECEIVE:
  - On each i_rx_done, i_rx_data is stored at slot [byte pointer] and the pointer increments.
  - When the byte that fills slot BYTES-1 arrives: state -> WRITE, the pointer clears, and the assembled word is loaded into o_wr_data.
- WRITE (exactly one cycle): o_wr_enable = 1, o_wr_addr = address.
  - If the word equals HALT_WORD: set o_end, go to IDLE.
  - Else if address = 2^MEMORY_ADDR_BUS_SIZE - 1: set o_overflow and o_end, go to IDLE.
  - Otherwise: address + 1, go to RECEIVE.
- i_rx_done during the WRITE cycle:
  - If continuing, the byte is stored as slot 0 of the next word (pointer becomes 1).
  - If terminating, the byte is discarded.
- i_start outside IDLE is ignored.
- Reset mid-operation: every register goes to its reset value immediately. The partial word is discarded and no write is issued. Memory contents already written are untouched.

## Timing
- Reset values: o_wr_enable=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_end=0, o_overflow=0, state IDLE.
- i_start sampled at edge S: o_busy=1 and o_end=0 from S. The first byte can be accepted at edge S+1.
- Last byte of a word sampled at edge N:
  - o_wr_enable high for the cycle N to N+1, with o_wr_addr/o_wr_data stable.
  - o_wr_data holds its value after the strobe.
- Termination decided at edge N+1: o_wr_enable=0, o_end=1 (plus o_overflow if applicable), o_busy=0 from N+1.
- Write latency: 1 cycle from the final byte to the strobe. There is no backpressure; the memory accepts a write every cycle.

## Test plan
- Reset: drive i_reset=0 asynchronously mid-cycle -> all outputs 0 immediately, o_busy=0.
- Basic load:
  - Stimulus: i_start, then bytes 78 56 34 12 EF BE AD DE FF FF FF FF.
  - Required: three one-cycle strobes: addr0=0x12345678, addr1=0xDEADBEEF, addr2=0xFFFFFFFF.
  - Then o_end=1 one cycle after the last strobe, o_overflow=0, o_busy=0.
- Back-to-back bytes:
  - Stimulus: i_rx_done every cycle, including the WRITE cycle, bytes 01 02 03 04 05 06 07 08.
  - Required: addr0=0x04030201, addr1=0x08070605; byte 05 is captured during the WRITE cycle.
- Overflow:
  - Stimulus: MEMORY_ADDR_BUS_SIZE=2, 16 bytes of 0x11.
  - Required: 4 writes of 0x11111111 at addr0..3, then o_overflow=1 and o_end=1.
  - Bytes sent afterwards produce no write.
- Reset mid-word: 2 bytes, then reset, then i_start and 4 bytes AA BB CC DD -> no strobe before reset; single write addr0=0xDDCCBBAA.
- Ignored inputs:
  - Byte 0x55 sent in IDLE -> no effect.
  - i_start pulsed mid-load -> address sequence unchanged.
  - Next i_start after o_end=1 -> o_end clears and o_wr_addr restarts at 0.

Source files
------------

// File: rtl/memory_loader_if.sv
// Receive-path bus between the UART/debug FSM side and the memory loader.
// Signal names keep the loader's port naming so both ends read the same.
interface memory_loader_if #(
   parameter int UART_BUS_SIZE        = 8,
   parameter int MEMORY_SLOT_SIZE     = 32,
   parameter int MEMORY_ADDR_BUS_SIZE = 10
);
   logic                            i_start;
   logic                            i_rx_done;
   logic [UART_BUS_SIZE-1:0]        i_rx_data;
   logic                            o_wr_enable;
   logic [MEMORY_ADDR_BUS_SIZE-1:0] o_wr_addr;
   logic [MEMORY_SLOT_SIZE-1:0]     o_wr_data;
   logic                            o_busy;
   logic                            o_end;
   logic                            o_overflow;

   modport slave (
      input  i_start, i_rx_done, i_rx_data,
      output o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_end, o_overflow
   );

   modport master (
      output i_start, i_rx_done, i_rx_data,
      input  o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_end, o_overflow
   );
endinterface

// File: rtl/memory_loader.sv
// Deserializes UART bytes (little-endian) into memory words and writes them to
// consecutive instruction-memory addresses until a halt word or memory is full.
module memory_loader #(
   parameter int                        UART_BUS_SIZE        = 8,
   parameter int                        MEMORY_SLOT_SIZE     = 32,
   parameter int                        MEMORY_ADDR_BUS_SIZE = 10,
   parameter logic [MEMORY_SLOT_SIZE-1:0] HALT_WORD          = 32'hFFFF_FFFF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   memory_loader_if.slave     bus
);
   localparam int BYTES = MEMORY_SLOT_SIZE / UART_BUS_SIZE;
   localparam int PTR_W = $clog2(BYTES) + 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(BYTES - 1);
   localparam logic [MEMORY_ADDR_BUS_SIZE-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_WRITE} state_t;

   state_t                                     r_state;
   logic [PTR_W-1:0]                           r_ptr;
   // The final byte of a word bypasses the buffer straight into o_wr_data.
   logic [BYTES-2:0][UART_BUS_SIZE-1:0]        r_buf;
   logic [MEMORY_ADDR_BUS_SIZE-1:0]            r_addr;
   logic                                       r_wr_en;
   logic [MEMORY_ADDR_BUS_SIZE-1:0]            r_wr_addr;
   logic [MEMORY_SLOT_SIZE-1:0]                r_wr_data;
   logic                                       r_busy;
   logic                                       r_end;
   logic                                       r_ovf;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_buf     <= '0;
         r_addr    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
         r_end     <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_state   <= S_RECEIVE;
                  r_ptr     <= '0;
                  r_addr    <= '0;
                  r_wr_addr <= '0;
                  r_end     <= 1'b0;
                  r_ovf     <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            S_RECEIVE: begin
               if (bus.i_rx_done) begin
                  if (r_ptr == LAST) begin
                     r_state   <= S_WRITE;
                     r_ptr     <= '0;
                     r_wr_data <= {bus.i_rx_data, r_buf};
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                  end else begin
                     r_buf[r_ptr[PTR_W-2:0]] <= bus.i_rx_data;
                     r_ptr                   <= r_ptr + PTR_W'(1);
                  end
               end
            end
            S_WRITE: begin
               r_wr_en <= 1'b0;
               if (r_wr_data == HALT_WORD || r_addr == ADDR_MAX) begin
                  r_state <= S_IDLE;
                  r_end   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_ovf   <= (r_wr_data != HALT_WORD);
               end else begin
                  r_state <= S_RECEIVE;
                  r_addr  <= r_addr + 1'b1;
                  // A byte landing in the strobe cycle starts the next word.
                  if (bus.i_rx_done) begin
                     r_buf[0] <= bus.i_rx_data;
                     r_ptr    <= PTR_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_wr_enable = r_wr_en;
   assign bus.o_wr_addr   = r_wr_addr;
   assign bus.o_wr_data   = r_wr_data;
   assign bus.o_busy      = r_busy;
   assign bus.o_end       = r_end;
   assign bus.o_overflow  = r_ovf;
endmodule
